maxpool_layer: RTL
==================

# maxpool_layer

Streaming 2x2, stride-2 max-pooling stage placed directly downstream of a convolution layer's activation unit (`conv_func`). It consumes one activation per cycle in raster order, channel-minor, and keeps per-channel running maxima in a half-width line buffer. For each pooled pixel it pulses a per-channel write into the next layer's per-channel input buffers (`conv_ibuf`).

## Interface
Parameters:
- `channels`, 5: number of channels in the stream; equals the upstream layer's `output_size`.
- `img_width`, 28: input image width and height (square). Must be even; elaboration `$error` otherwise.
- `datatype_size`, 4: activation width, signed two's complement.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: start one frame. Ignored unless in S_IDLE.
- `i_valid` in 1: upstream data valid.
- `i_data` in `datatype_size`: activation for the current (row, col, ch).
- `o_ready` out 1: block accepts `i_data` this cycle. A transfer occurs when `i_valid & o_ready`.
- `i_next_busy` in 1: downstream layer cannot take writes.
- `o_ibuf_we` out [channels-1:0] x 1: one-hot write pulse.
- `o_ibuf_wr_data` out [channels-1:0] x `datatype_size`: pooled value; meaningful only on the lane whose `we` is high.
- `o_busy` out 1: state is not S_IDLE.
- `o_done` out 1: one-cycle pulse after the final pooled write of a frame.

## Operation
- Input order: for row 0..W-1, for col 0..W-1, for ch 0..C-1.
- Counters `ch`, `col`, `row` advance on each transfer, with wrap ch→col→row.
- Per-channel horizontal register `hreg[ch]` and line buffer `lbuf[ch][col/2]` (C·W/2 entries). Handling by position:
  - Even col: `hreg[ch] <= x`.
  - Odd col, even row: `lbuf[ch][col/2] <= max(hreg[ch], x)`.
  - Odd col, odd row: `res = max(lbuf[ch][col/2], hreg[ch], x)`; load the output register, lane `ch`.
- `max` is a signed comparison. On ties, either operand may be taken; the value is identical.
- FSM:
  - S_IDLE (`o_ready=0`): on `i_start`, clear counters and go to S_RUN.
  - S_RUN (`o_ready=1`): on a transfer that loads the output register while `i_next_busy=1`, go to S_HOLD. On the transfer of sample (W-1, W-1, C-1), go to S_FLUSH.
  - S_HOLD (`o_ready=0`): keep the output pending. When `i_next_busy=0`, emit the write and return to S_RUN, or to S_FLUSH if the final sample was already taken.
  - S_FLUSH (`o_ready=0`): once the last write has been emitted, pulse `o_done` and go to S_IDLE.
- Write emission: a pending output drives `o_ibuf_we[lane]=1` for exactly one cycle, and only in a cycle with `i_next_busy=0`.
- Lanes other than the pending lane have `we=0`. Their `wr_data` holds its last value.
- At most one write is pending at a time. `o_ready` is low whenever a write is pending and `i_next_busy=1`.
- Reset mid-frame: all state returns to S_IDLE, any pending write is discarded, and `lbuf` contents are don't-care.

## Timing
- Reset values: `o_ready=0`, `o_ibuf_we=0`, `o_ibuf_wr_data=0`, `o_busy=0`, `o_done=0`. Counters, `hreg` and the output register are cleared.
- Latency: a pooled write appears 1 cycle after the transfer of the completing sample, provided `i_next_busy=0` in that cycle.
- Throughput: 1 sample/cycle sustained; no bubbles while `i_next_busy=0`.
- `o_done` is asserted 1 cycle after the last `we` pulse.
- `o_busy` rises the cycle after `i_start` is sampled in S_IDLE.
- `i_start` is ignored while busy.
- `lbuf` read and write occur in the same cycle on the same address only for an even/odd row pair. Since reads happen only on odd rows and writes only on even rows, there is no read-during-write hazard.

## Configuration
- `MAXPOOL_RELU_EN` defined: the output is `(res < 0) ? 0 : res` (fused ReLU).
- `MAXPOOL_RELU_EN` undefined: `res` is passed through unmodified, negative values included.

## Structure
- Shared package `pool_pkg` holds:
  - the FSM state enum `pool_state_t` {S_IDLE, S_RUN, S_HOLD, S_FLUSH};
  - `POOL_DIM=2`;
  - a function `smax(a,b)` for signed max.
- One sub-module, `pool_linebuf`: C·W/2-entry, `datatype_size`-wide memory. It has one synchronous-write port and one combinational-read port addressed by {ch, col/2}, and reset-free storage.

## Test plan
- C=1, W=4, ramp input 0..15 (row-major), `i_next_busy=0`: exactly 4 writes with values 5, 7, 13, 15, then `o_done` 1 cycle after the last write.
- C=2, W=2, samples ch0={1,-3,2,0}, ch1={-8,-2,-5,-7}: ch0 write 2, then ch1 write -2. With `MAXPOOL_RELU_EN`, the ch1 write is 0.
- Backpressure: hold `i_next_busy=1` for 5 cycles when the first pooled result is ready: `o_ready` low for those cycles, a single `we` pulse with the correct value after release, and no lost or duplicated samples.
- Reset asserted mid-frame with a write pending: no `we` pulse afterwards. A new `i_start` then runs a full frame producing correct values.
- `i_start` pulsed while busy: ignored. Two back-to-back frames, with `i_start` issued after `o_done`, both pool correctly (no stale `lbuf`/`hreg` effect).
- Random `i_valid` and `i_next_busy` over C=5, W=28: scoreboard matches a reference model across all 980 writes.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pooling stage: FSM states, pool geometry
// and a signed-max helper.
package pool_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_FLUSH
    } pool_state_t;

    localparam int POOL_DIM = 2;
    localparam int SMAX_W   = 32;

    // Callers sign-extend into SMAX_W bits and truncate the result back.
    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-width line buffer holding per-channel horizontal maxima of the previous
// even row; one synchronous write port, one combinational read port.
module pool_linebuf #(
    parameter int channels      = 5,
    parameter int depth         = 14,
    parameter int datatype_size = 4,
    parameter int CH_W          = (channels > 1) ? $clog2(channels) : 1,
    parameter int IDX_W         = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [CH_W-1:0]          i_wr_ch,
    input  logic [IDX_W-1:0]         i_wr_idx,
    input  logic [datatype_size-1:0] i_wr_data,
    input  logic [CH_W-1:0]          i_rd_ch,
    input  logic [IDX_W-1:0]         i_rd_idx,
    output logic [datatype_size-1:0] o_rd_data
);

    logic [datatype_size-1:0] mem_q [channels][depth];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_wr_ch][i_wr_idx] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data = mem_q[i_rd_ch][i_rd_idx];
    end

endmodule

// File: rtl/maxpool_layer.sv
// Streaming 2x2 stride-2 max-pooling stage with per-channel one-hot write-out.
// Build option: define MAXPOOL_RELU_EN to clamp pooled results at zero.
module maxpool_layer
    import pool_pkg::*;
#(
    parameter int channels      = 5,
    parameter int img_width     = 28,
    parameter int datatype_size = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_start,
    input  logic                                    i_valid,
    input  logic [datatype_size-1:0]                i_data,
    output logic                                    o_ready,
    input  logic                                    i_next_busy,
    output logic [channels-1:0]                     o_ibuf_we,
    output logic [channels-1:0][datatype_size-1:0]  o_ibuf_wr_data,
    output logic                                    o_busy,
    output logic                                    o_done
);

    localparam int CH_W  = (channels > 1) ? $clog2(channels) : 1;
    localparam int COL_W = (img_width > 1) ? $clog2(img_width) : 1;
    localparam int HALF  = img_width / POOL_DIM;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(channels - 1);
    localparam logic [COL_W-1:0] POS_LAST = COL_W'(img_width - 1);

    generate
        if (img_width % POOL_DIM != 0) begin : g_odd_width
            $error("maxpool_layer: img_width must be even");
        end
    endgenerate

    pool_state_t state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] row_q, row_d;
    logic signed [datatype_size-1:0] hreg_q [channels];
    logic signed [datatype_size-1:0] hreg_d [channels];
    logic             pend_q, pend_d;
    logic [CH_W-1:0]  lane_q, lane_d;
    logic [channels-1:0][datatype_size-1:0] wr_data_q, wr_data_d;

    logic xfer, emit, last_sample, lb_we;
    logic [IDX_W-1:0] lb_idx;
    logic signed [datatype_size-1:0] x, h_cur, h_max, lb_rd, pooled, pooled_out;

    pool_linebuf #(
        .channels      (channels),
        .depth         (HALF),
        .datatype_size (datatype_size)
    ) u_linebuf (
        .clk       (clk),
        .i_we      (lb_we),
        .i_wr_ch   (ch_q),
        .i_wr_idx  (lb_idx),
        .i_wr_data (h_max),
        .i_rd_ch   (ch_q),
        .i_rd_idx  (lb_idx),
        .o_rd_data (lb_rd)
    );

    always_comb begin
        x      = signed'(i_data);
        h_cur  = hreg_q[ch_q];
        lb_idx = IDX_W'(col_q >> 1);
        h_max  = datatype_size'(smax(SMAX_W'(h_cur), SMAX_W'(x)));
        pooled = datatype_size'(smax(SMAX_W'(lb_rd), SMAX_W'(h_max)));
`ifdef MAXPOOL_RELU_EN
        pooled_out = pooled[datatype_size-1] ? '0 : pooled;
`else
        pooled_out = pooled;
`endif
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        col_d     = col_q;
        row_d     = row_q;
        hreg_d    = hreg_q;
        pend_d    = pend_q;
        lane_d    = lane_q;
        wr_data_d = wr_data_q;
        o_ready   = 1'b0;
        o_done    = 1'b0;
        emit      = 1'b0;
        lb_we     = 1'b0;
        last_sample = (row_q == POS_LAST) && (col_q == POS_LAST) && (ch_q == CH_LAST);

        // o_ready drops combinationally when a pending write meets downstream
        // backpressure, so a new result can never overwrite an unsent one.
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    ch_d    = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                o_ready = !(pend_q && i_next_busy);
                emit    = pend_q && !i_next_busy;
                if (pend_q && i_next_busy) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                emit = pend_q && !i_next_busy;
                if (!i_next_busy) begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                emit = pend_q && !i_next_busy;
                if (!pend_q) begin
                    o_done  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        xfer = i_valid && o_ready;
        if (emit) begin
            pend_d = 1'b0;
        end

        if (xfer) begin
            if (!col_q[0]) begin
                hreg_d[ch_q] = x;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                // Lane data updates at load; other lanes keep their last value.
                pend_d          = 1'b1;
                lane_d          = ch_q;
                wr_data_d[ch_q] = pooled_out;
            end

            if (ch_q == CH_LAST) begin
                ch_d = '0;
                if (col_q == POS_LAST) begin
                    col_d = '0;
                    row_d = (row_q == POS_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end

            if (last_sample) begin
                state_d = S_FLUSH;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < channels; i++) begin
            o_ibuf_we[i] = emit && (lane_q == CH_W'(i));
        end
        o_ibuf_wr_data = wr_data_q;
        o_busy         = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            hreg_q    <= '{default: '0};
            pend_q    <= 1'b0;
            lane_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            col_q     <= col_d;
            row_q     <= row_d;
            hreg_q    <= hreg_d;
            pend_q    <= pend_d;
            lane_q    <= lane_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule
